// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// REGFILE_ARB_RR_EN (see regfile_arb_starve) selects round-robin fairness.
package regfile_arb_pkg;
    typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_MEM} grant_t;

    localparam int STARVE_CNT_W         = 4;
    localparam int DEFAULT_STARVE_LIMIT = 4;
endpackage

// File: rtl/regfile_arb_starve.sv
// Fairness tracker for the writeback arbiter: starvation counter by default,
// 1-bit round-robin pointer when REGFILE_ARB_RR_EN is defined.
module regfile_arb_starve
    import regfile_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic mem_valid,
    input  logic alu_gnt,
    output logic force_alu
);

`ifdef REGFILE_ARB_RR_EN
    // ptr = 1 means the ALU wins the next contention; only contention moves it.
    logic ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= 1'b0;
        else if (alu_valid && mem_valid)
            ptr <= ~alu_gnt;
    end

    assign force_alu = ptr;
`else
    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (!alu_valid || alu_gnt)
            starve_cnt <= '0;
        else if (starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Only meaningful under contention; a lone ALU request wins anyway.
    assign force_alu = alu_valid && mem_valid && (starve_cnt == LIMIT);
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU and load writeback.
// Define REGFILE_ARB_RR_EN for round-robin instead of mem priority + starvation guard.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = DEFAULT_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     we3,
    output logic [ADDRESS_WIDTH-1:0] ad3,
    output logic [DATA_WIDTH-1:0]    wd3,
    output logic                     starved
);

    grant_t gnt;
    logic   force_alu;

    regfile_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .alu_valid(alu_valid),
        .mem_valid(mem_valid),
        .alu_gnt  (alu_ready),
        .force_alu(force_alu)
    );

    always_comb begin
        gnt = GNT_NONE;
        if (rst)
            gnt = GNT_NONE;
        else if (alu_valid && mem_valid)
            gnt = force_alu ? GNT_ALU : GNT_MEM;
        else if (alu_valid)
            gnt = GNT_ALU;
        else if (mem_valid)
            gnt = GNT_MEM;
    end

    assign alu_ready = (gnt == GNT_ALU);
    assign mem_ready = (gnt == GNT_MEM);

`ifdef REGFILE_ARB_RR_EN
    assign starved = 1'b0;
`else
    assign starved = force_alu && !rst;
`endif

    // Writes to x0 are accepted but leave we3 low so register 0 stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3 <= 1'b0;
            ad3 <= '0;
            wd3 <= '0;
        end else begin
            case (gnt)
                GNT_ALU: begin
                    we3 <= (alu_rd != '0);
                    ad3 <= alu_rd;
                    wd3 <= alu_data;
                end
                GNT_MEM: begin
                    we3 <= (mem_rd != '0);
                    ad3 <= mem_rd;
                    wd3 <= mem_data;
                end
                default: we3 <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, hand sequences, random vs model.
module tb_regfile_wb_arbiter;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0, mem_rd = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          alu_ready, mem_ready, we3, starved;
    logic [AW-1:0] ad3;
    logic [DW-1:0] wd3;

    regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .we3(we3), .ad3(ad3), .wd3(wd3), .starved(starved)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic av; logic [AW-1:0] ard; logic [DW-1:0] adat;
        logic mv; logic [AW-1:0] mrd; logic [DW-1:0] mdat;
        logic ar; logic mr; logic we; logic [AW-1:0] wa; logic [DW-1:0] wd;
    } vec_t;

    function automatic vec_t mk(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                                input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdat,
                                input logic ar, input logic mr, input logic we,
                                input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat; v.mv = mv; v.mrd = mrd; v.mdat = mdat;
        v.ar = ar; v.mr = mr; v.we = we; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    task automatic chk_out(input string tag, input logic ewe, input logic [AW-1:0] ead,
                           input logic [DW-1:0] ewd);
        chk({tag, ".we3"}, 32'(we3), 32'(ewe));
        if (ewe) begin
            chk({tag, ".ad3"}, 32'(ad3), 32'(ead));
            chk({tag, ".wd3"}, wd3, ewd);
        end
    endtask

    vec_t tbl[15];

    // Reference model state: output register contents and ALU denial streak.
    logic          m_we, m_favor_alu;
    logic [AW-1:0] m_ad;
    logic [DW-1:0] m_wd;
    int            m_denied, alu_age;

    initial begin
        logic          e_alu, e_mem, e_st, prev_we;
        logic [AW-1:0] prev_ad;
        logic [DW-1:0] prev_wd;
        int            n_alu, n_mem;

        tbl[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,            1, 0, 1, 5,  32'hDEADBEEF);
        tbl[1]  = mk(0, 0,  0,            1, 0,  32'h00001234, 0, 1, 0, 0,  0);
        tbl[2]  = mk(0, 0,  0,            0, 0,  0,            0, 0, 0, 0,  0);
        tbl[3]  = mk(0, 0,  0,            1, 31, 32'hCAFEF00D, 0, 1, 1, 31, 32'hCAFEF00D);
        tbl[4]  = mk(1, 0,  32'h0000FFFF, 0, 0,  0,            1, 0, 0, 0,  0);
        tbl[5]  = mk(1, 1,  32'h11111111, 0, 0,  0,            1, 0, 1, 1,  32'h11111111);
        tbl[6]  = mk(0, 0,  0,            1, 2,  32'h22222222, 0, 1, 1, 2,  32'h22222222);
        tbl[7]  = mk(1, 3,  32'h33333333, 0, 0,  0,            1, 0, 1, 3,  32'h33333333);
        tbl[8]  = mk(0, 0,  0,            1, 4,  32'h44444444, 0, 1, 1, 4,  32'h44444444);
        tbl[9]  = mk(1, 5,  32'h55555555, 0, 0,  0,            1, 0, 1, 5,  32'h55555555);
        tbl[10] = mk(0, 0,  0,            1, 6,  32'h66666666, 0, 1, 1, 6,  32'h66666666);
        tbl[11] = mk(1, 7,  32'h77777777, 0, 0,  0,            1, 0, 1, 7,  32'h77777777);
        tbl[12] = mk(0, 0,  0,            1, 8,  32'h88888888, 0, 1, 1, 8,  32'h88888888);
        tbl[13] = mk(0, 0,  0,            0, 0,  0,            0, 0, 0, 0,  0);
        tbl[14] = mk(0, 0,  0,            0, 0,  0,            0, 0, 0, 0,  0);

        // Reset state, with both requesters pushing to confirm readys are held low.
        alu_valid = 1'b1; mem_valid = 1'b1;
        #2;
        chk("rst.we3", 32'(we3), 0);
        chk("rst.ad3", 32'(ad3), 0);
        chk("rst.wd3", wd3, 0);
        chk("rst.starved", 32'(starved), 0);
        chk("rst.alu_ready", 32'(alu_ready), 0);
        chk("rst.mem_ready", 32'(mem_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table: each row drives one cycle; its write shows up during the next row.
        for (int i = 0; i < 15; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
            mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].mdat;
            @(negedge clk);
            chk($sformatf("tbl%0d.alu_ready", i), 32'(alu_ready), 32'(tbl[i].ar));
            chk($sformatf("tbl%0d.mem_ready", i), 32'(mem_ready), 32'(tbl[i].mr));
            if (i > 0)
                chk_out($sformatf("tbl%0d", i - 1), tbl[i-1].we, tbl[i-1].wa, tbl[i-1].wd);
            @(posedge clk); #1;
        end

        // Contention: both always valid; each side re-presents a new request once accepted.
        n_alu = 0; n_mem = 0; prev_we = 1'b0; prev_ad = '0; prev_wd = '0;
        for (int k = 0; k < 15; k++) begin
            alu_valid = 1'b1; alu_rd = 10; alu_data = 32'hA0000000 + n_alu;
            mem_valid = 1'b1; mem_rd = 20; mem_data = 32'hB0000000 + n_mem;
`ifdef REGFILE_ARB_RR_EN
            e_alu = (k % 2) == 1;
            e_st  = 1'b0;
`else
            e_alu = (k % (LIM + 1)) == LIM;
            e_st  = e_alu;
`endif
            @(negedge clk);
            chk($sformatf("cont%0d.alu_ready", k), 32'(alu_ready), 32'(e_alu));
            chk($sformatf("cont%0d.mem_ready", k), 32'(mem_ready), 32'(!e_alu));
            chk($sformatf("cont%0d.starved", k), 32'(starved), 32'(e_st));
            chk_out($sformatf("cont%0d", k), prev_we, prev_ad, prev_wd);
            @(posedge clk); #1;
            prev_we = 1'b1;
            prev_ad = e_alu ? 5'd10 : 5'd20;
            prev_wd = e_alu ? 32'hA0000000 + n_alu : 32'hB0000000 + n_mem;
            if (e_alu) n_alu++; else n_mem++;
        end

        // Reset mid-operation: pending write is discarded immediately.
        mem_valid = 1'b0; alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h77;
        @(negedge clk);
        chk("mid.alu_ready", 32'(alu_ready), 1);
        @(posedge clk); #1;
        chk("mid.pending_we3", 32'(we3), 1);
        mem_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("mid.we3", 32'(we3), 0);
        chk("mid.ad3", 32'(ad3), 0);
        chk("mid.wd3", wd3, 0);
        chk("mid.alu_ready", 32'(alu_ready), 0);
        chk("mid.mem_ready", 32'(mem_ready), 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid.hold_alu_ready", 32'(alu_ready), 0);
            chk("mid.hold_mem_ready", 32'(mem_ready), 0);
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("mid.re_alu_ready", 32'(alu_ready), 1);
        @(posedge clk); #1;
        alu_valid = 1'b0;
        @(negedge clk);
        chk_out("mid.re", 1'b1, 5'd7, 32'h77);

        // Fresh reset, then random traffic against the model.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_we = 1'b0; m_ad = '0; m_wd = '0; m_denied = 0; m_favor_alu = 1'b0; alu_age = 0;
        for (int c = 0; c < 600; c++) begin
            if (!alu_valid && $urandom_range(0, 99) < 65) begin
                alu_valid = 1'b1;
                alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
                alu_data  = $urandom;
            end
            if (!mem_valid && $urandom_range(0, 99) < 65) begin
                mem_valid = 1'b1;
                mem_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom);
                mem_data  = $urandom;
            end
`ifdef REGFILE_ARB_RR_EN
            e_alu = alu_valid && (!mem_valid || m_favor_alu);
            e_st  = 1'b0;
`else
            e_alu = alu_valid && (!mem_valid || m_denied == LIM);
            e_st  = alu_valid && mem_valid && m_denied == LIM;
`endif
            e_mem = mem_valid && !e_alu;
            @(negedge clk);
            chk($sformatf("rnd%0d.alu_ready", c), 32'(alu_ready), 32'(e_alu));
            chk($sformatf("rnd%0d.mem_ready", c), 32'(mem_ready), 32'(e_mem));
            chk($sformatf("rnd%0d.starved", c), 32'(starved), 32'(e_st));
            chk_out($sformatf("rnd%0d", c), m_we, m_ad, m_wd);
            // Observed ALU wait, from the DUT's own readys, must stay within the fairness bound.
            if (alu_valid && alu_ready) begin
`ifdef REGFILE_ARB_RR_EN
                chk($sformatf("rnd%0d.alu_wait_ok", c), 32'(alu_age <= 1), 1);
`else
                chk($sformatf("rnd%0d.alu_wait_ok", c), 32'(alu_age <= LIM), 1);
`endif
                alu_age = 0;
            end else if (alu_valid) begin
                alu_age++;
            end
            @(posedge clk);
            if (e_alu) begin
                m_we = (alu_rd != 0); m_ad = alu_rd; m_wd = alu_data;
            end else if (e_mem) begin
                m_we = (mem_rd != 0); m_ad = mem_rd; m_wd = mem_data;
            end else begin
                m_we = 1'b0;
            end
            if (alu_valid && mem_valid) m_favor_alu = e_mem;
            if (alu_valid && !e_alu) m_denied = (m_denied + 1 > LIM) ? LIM : m_denied + 1;
            else m_denied = 0;
            #1;
            if (e_alu) alu_valid = 1'b0;
            if (e_mem) mem_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbitrates the single register-file write port between two writeback requesters: the ALU result path and the load/memory return path. Each requester presents a valid/ready write request (destination register plus data). The block grants one request per cycle and drives a registered write strobe, address and data straight onto the register file's WE3/AD3/WD3 inputs. Fixed memory priority is protected by a starvation counter, so the ALU path is never locked out indefinitely.

## Interface
- ADDRESS_WIDTH, 5, register index width
- DATA_WIDTH, 32, write data width
- STARVE_LIMIT, 4, consecutive denied ALU cycles before a forced ALU grant (1..15)

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU write request
- alu_ready  output  1  ALU request accepted this cycle
- alu_rd  input  ADDRESS_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU write data
- mem_valid  input  1  load write request
- mem_ready  output  1  load request accepted this cycle
- mem_rd  input  ADDRESS_WIDTH  load destination register
- mem_data  input  DATA_WIDTH  load write data
- we3  output  1  register-file write enable
- ad3  output  ADDRESS_WIDTH  register-file write address
- wd3  output  DATA_WIDTH  register-file write data
- starved  output  1  forced ALU grant is being issued this cycle

## Operation
- Handshake: a transfer occurs when valid && ready at a rising edge. After valid rises, the requester holds valid, rd and data stable until ready.
- ready is combinational from the current grant. At most one of alu_ready and mem_ready is high. A ready output is never high without its matching valid.
- Grant selection:
  - only one requester valid: that requester is granted;
  - both valid: mem is granted, unless starve_cnt == STARVE_LIMIT, in which case alu is granted and starved = 1;
  - neither valid: no grant.
- starve_cnt is 4 bits:
  - increments when alu_valid && !alu_ready, saturating at STARVE_LIMIT;
  - clears on any ALU grant or when alu_valid is low.
- An accepted request with rd == 0 completes the handshake normally but produces we3 = 0. The write is silently dropped, so register 0 stays zero.
- Arbitration ignores rd. Ordering between writes to the same rd from the two paths is the responsibility of the upstream pipeline.
- Output stage: one register holding we3/ad3/wd3, reloaded every cycle. With no grant, it loads we3 = 0 and keeps ad3/wd3 at their previous values.

## Timing
- Latency: a request accepted at edge N drives we3/ad3/wd3 during cycle N+1. The register file commits it at edge N+1.
- Throughput: one write per cycle, sustained.
- Reset (asynchronous assert):
  - we3 = 0, ad3 = 0, wd3 = 0, starve_cnt = 0, starved = 0;
  - alu_ready and mem_ready are forced to 0 while rst is high.
- Reset mid-operation: a write pending in the output register is discarded. Requesters must re-present it after reset.
- Simultaneous events: a forced grant and the mem request arriving on the same cycle resolve to the ALU; mem waits exactly one cycle.
- Saturation: starve_cnt never exceeds STARVE_LIMIT. Worst-case ALU wait is STARVE_LIMIT cycles.

## Configuration
- REGFILE_ARB_RR_EN defined:
  - the starvation counter is replaced by a 1-bit round-robin pointer;
  - on contention, the requester not granted last is granted, then the pointer flips;
  - the pointer resets to favour mem;
  - starved is tied to 0.
- REGFILE_ARB_RR_EN undefined: fixed mem priority with the starvation counter, as described in Operation.

## Structure
- Package regfile_arb_pkg holds:
  - typedef enum logic [1:0] grant_t {GNT_NONE, GNT_ALU, GNT_MEM};
  - localparam STARVE_CNT_W = 4;
  - the default STARVE_LIMIT constant.
- One sub-module, regfile_arb_starve: owns starve_cnt (or the RR pointer under REGFILE_ARB_RR_EN) and emits force_alu. The top level holds grant decode and the output register.

## Test plan
- Reset: assert rst mid-cycle with a pending write -> we3 = 0, ad3 = 0, wd3 = 0 immediately; both readys 0 until rst falls.
- Single ALU write: alu_valid, rd = 5, data = 0xDEADBEEF -> alu_ready in the same cycle; the next cycle shows we3 = 1, ad3 = 5, wd3 = 0xDEADBEEF.
- Contention: both valid continuously, STARVE_LIMIT = 4 -> mem granted 4 cycles, ALU granted on the 5th with starved = 1, then mem resumes.
- x0 drop: mem_valid, rd = 0, data = 0x1234 -> mem_ready = 1; the next cycle has we3 = 0.
- Back-to-back: alternate valid requests over 8 cycles -> 8 consecutive we3 pulses with matching ad3/wd3, no bubbles.
- REGFILE_ARB_RR_EN build: both valid continuously -> grants alternate mem, alu, mem, alu…; starved stays 0.
